// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster scanner with colour-latency-aligned DAC outputs.
// Purpose : Scans x/y across the full raster and requests pixel colours.
//           It drives sync, blank, pixel clock and RGB to the VGA DAC.
//           Sync and blank are delayed to line up with the colour logic.
// Ports   : clk/rst (async, active-high)
//           color  : {R,G,B} returned for the x/y issued PIX_LAT clk earlier
//           x/y    : raster counters
//           frame_start : one-clk pulse when x/y become (0,0)
//           vga_*  : DAC/connector signals (clk, hs, vs, blank_n, sync_n, r, g, b)
// Latency : DAC outputs describe the pixel whose coordinate appeared PIX_LAT+1 clk earlier.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int PIX_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] color,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        frame_start,
  output logic        vga_clk,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0]       X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       Y_LAST   = 10'(V_TOTAL - 1);

  // Parameter sanity: the 10-bit counters must cover the raster.
  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be even and >= 2");
  end
  if (PIX_LAT < 0 || PIX_LAT > 7) begin : g_bad_lat
    $error("vga_timing_gen: PIX_LAT must be 0..7");
  end

  // ---------------------------------------------------------------------------
  // Pixel divider and raster counters
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             fs_q, fs_d;
  logic             vclk_q, vclk_d;
  logic             ce;

  assign ce = (div_q == DIV_LAST);

  always_comb begin
    div_d = ce ? '0 : div_q + DIV_W'(1);
    x_d   = x_q;
    y_d   = y_q;
    fs_d  = 1'b0;
    if (ce) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;  // registered with x/y, so it is high while x/y read (0,0)
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Pixel clock is built from the next divider value and registered so the
    // DAC clock is glitch-free; high for the second half of each pixel.
    vclk_d = (div_d >= DIV_HALF);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      fs_q   <= 1'b0;
      vclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      x_q    <= x_d;
      y_q    <= y_d;
      fs_q   <= fs_d;
      vclk_q <= vclk_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign vga_clk     = vclk_q;

  // ---------------------------------------------------------------------------
  // Raw timing decode from the live counters
  // ---------------------------------------------------------------------------
  logic act_raw, hs_raw, vs_raw;

  always_comb begin
    act_raw = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
    hs_raw  = !((int'(x_q) >= HS_START) && (int'(x_q) < HS_END));
    vs_raw  = !((int'(y_q) >= VS_START) && (int'(y_q) < VS_END));
  end

  // ---------------------------------------------------------------------------
  // Delay line matching the colour-logic latency
  // ---------------------------------------------------------------------------
  logic act_dly, hs_dly, vs_dly;

  if (PIX_LAT > 0) begin : g_shift
    logic [PIX_LAT-1:0] act_sh_q;
    logic [PIX_LAT-1:0] hs_sh_q;
    logic [PIX_LAT-1:0] vs_sh_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        act_sh_q <= '0;
        hs_sh_q  <= '1;  // syncs are active-low, so "inactive" is all ones
        vs_sh_q  <= '1;
      end else begin
        act_sh_q[0] <= act_raw;
        hs_sh_q[0]  <= hs_raw;
        vs_sh_q[0]  <= vs_raw;
        for (int i = 1; i < PIX_LAT; i++) begin
          act_sh_q[i] <= act_sh_q[i-1];
          hs_sh_q[i]  <= hs_sh_q[i-1];
          vs_sh_q[i]  <= vs_sh_q[i-1];
        end
      end
    end

    assign act_dly = act_sh_q[PIX_LAT-1];
    assign hs_dly  = hs_sh_q[PIX_LAT-1];
    assign vs_dly  = vs_sh_q[PIX_LAT-1];
  end else begin : g_noshift
    assign act_dly = act_raw;
    assign hs_dly  = hs_raw;
    assign vs_dly  = vs_raw;
  end

  // ---------------------------------------------------------------------------
  // DAC output register: everything here describes the same pixel
  // ---------------------------------------------------------------------------
  logic        hs_q, vs_q, blank_n_q;
  logic [23:0] rgb_q, rgb_d;

  // Colour is forced to black outside the visible area so porch/sync
  // intervals never carry stray colour from the game logic.
  assign rgb_d = act_dly ? color : 24'h000000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hs_dly;
      vs_q      <= vs_dly;
      blank_n_q <= act_dly;
      rgb_q     <= rgb_d;
    end
  end

  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: drives vga_timing_gen with a reduced raster, random run
// lengths, random mid-frame resets and three colour sources; every cycle the
// outputs are compared with an arithmetic model of the raster.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 6;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int CD = 2,  LAT = 2;
  localparam int HT = HA + HF + HS + HB;   // 32
  localparam int VT = VA + VF + VS + VB;   // 15
  localparam int FRAME = HT * VT * CD;     // 960

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] color = 24'h0;
  logic [9:0]  x, y;
  logic        frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .PIX_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst), .color(color),
    .x(x), .y(y), .frame_start(frame_start),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          k       = 0;     // clk edges since reset release
  int          mode    = 0;     // 0: pattern {x,y,A5}, 1: FFFFFF, 2: random constant
  int          ep      = 0;
  logic [23:0] const_col = 24'hFFFFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", name, act, exp, k);
    end
  endtask

  // Colour-logic stand-in: returns the colour for the coordinate seen 2 clk earlier.
  logic [9:0] xh0 = 0, xh1 = 0, xh2 = 0, yh0 = 0, yh1 = 0, yh2 = 0;
  always @(posedge clk) begin
    if (rst) k = 0;
    else     k = k + 1;
    #1;
    xh2 = xh1; xh1 = xh0; xh0 = x;
    yh2 = yh1; yh1 = yh0; yh0 = y;
    if (mode == 0) color = {xh2[7:0], yh2[7:0], 8'hA5};
    else           color = const_col;
  end

  // First-episode event log, pinned to hand-computed literals later.
  int hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
  int bl_rise = -1, bl_fall = -1, fs1 = -1, fs2 = -1;
  logic [23:0] rgb_k3 = 24'h0;
  logic prev_hs = 1'b1, prev_vs = 1'b1, prev_bl = 1'b0;

  always @(negedge clk) begin
    int p, ex, ey, j, jp, jx, jy;
    logic eact, ehs, evs, evclk, efs;
    logic [23:0] ergb;
    check("sync_n", {31'd0, vga_sync_n}, 32'd0);
    if (rst) begin
      check("rst_x", {22'd0, x}, 32'd0);
      check("rst_y", {22'd0, y}, 32'd0);
      check("rst_fs", {31'd0, frame_start}, 32'd0);
      check("rst_vclk", {31'd0, vga_clk}, 32'd0);
      check("rst_hs", {31'd0, vga_hs}, 32'd1);
      check("rst_vs", {31'd0, vga_vs}, 32'd1);
      check("rst_blank", {31'd0, vga_blank_n}, 32'd0);
      check("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    end else begin
      p     = k / CD;
      ex    = p % HT;
      ey    = (p / HT) % VT;
      evclk = ((k % CD) >= CD / 2);
      efs   = (k > 0) && ((k % FRAME) == 0);
      if (k >= LAT + 1) begin
        j    = k - LAT - 1;
        jp   = j / CD;
        jx   = jp % HT;
        jy   = (jp / HT) % VT;
        eact = (jx < HA) && (jy < VA);
        ehs  = !((jx >= HA + HF) && (jx < HA + HF + HS));
        evs  = !((jy >= VA + VF) && (jy < VA + VF + VS));
        if (!eact)          ergb = 24'h0;
        else if (mode == 0) ergb = {jx[7:0], jy[7:0], 8'hA5};
        else                ergb = const_col;
      end else begin
        eact = 1'b0; ehs = 1'b1; evs = 1'b1; ergb = 24'h0;
      end
      check("x", {22'd0, x}, ex);
      check("y", {22'd0, y}, ey);
      check("vga_clk", {31'd0, vga_clk}, {31'd0, evclk});
      check("frame_start", {31'd0, frame_start}, {31'd0, efs});
      check("vga_hs", {31'd0, vga_hs}, {31'd0, ehs});
      check("vga_vs", {31'd0, vga_vs}, {31'd0, evs});
      check("blank_n", {31'd0, vga_blank_n}, {31'd0, eact});
      check("rgb", {8'd0, vga_r, vga_g, vga_b}, {8'd0, ergb});

      if (ep == 0) begin
        if (prev_hs && !vga_hs && hs_fall < 0) hs_fall = k;
        if (!prev_hs && vga_hs && hs_rise < 0) hs_rise = k;
        if (prev_vs && !vga_vs && vs_fall < 0) vs_fall = k;
        if (!prev_vs && vga_vs && vs_rise < 0) vs_rise = k;
        if (!prev_bl && vga_blank_n && bl_rise < 0) bl_rise = k;
        if (prev_bl && !vga_blank_n && bl_fall < 0) bl_fall = k;
        if (frame_start) begin
          if (fs1 < 0)      fs1 = k;
          else if (fs2 < 0) fs2 = k;
        end
        if (k == 3) rgb_k3 = {vga_r, vga_g, vga_b};
        prev_hs = vga_hs;
        prev_vs = vga_vs;
        prev_bl = vga_blank_n;
      end
    end
  end

  initial begin
    int n;
    // Episode 0: two full frames of the pattern source from a clean reset.
    rst = 1'b1;
    mode = 0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    repeat (2000) @(posedge clk);
    #2 rst = 1'b1;
    ep = 1;
    // Hand-derived event times for the 32x15 raster, CLK_DIV=2, PIX_LAT=2.
    check("lit_hs_fall", hs_fall, 43);     // x=20 at k=40, +3
    check("lit_hs_rise", hs_rise, 55);     // 6 pixels * 2 clk low
    check("lit_vs_fall", vs_fall, 643);    // y=10,x=0 at k=640, +3
    check("lit_vs_rise", vs_rise, 771);    // 2 lines * 64 clk low
    check("lit_blank_rise", bl_rise, 3);
    check("lit_blank_fall", bl_fall, 35);  // x=16 at k=32, +3
    check("lit_fs1", fs1, 960);
    check("lit_fs2", fs2, 1920);
    check("lit_rgb_k3", {8'd0, rgb_k3}, 32'h0000_00A5);

    // Random episodes: random colour source, run length and mid-frame reset point.
    for (int e = 0; e < 10; e++) begin
      mode = int'($urandom_range(0, 2));
      const_col = (mode == 1) ? 24'hFFFFFF : 24'($urandom);
      n = int'($urandom_range(2, 4));
      repeat (n) @(posedge clk);
      #3 rst = 1'b0;
      n = int'($urandom_range(40, 1500));
      repeat (n) @(posedge clk);
      #2 rst = 1'b1;
    end
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates the VGA raster for the Breakout display path. It scans the screen and issues pixel coordinates `x`/`y` to the pixel-colour logic, then takes back the 24-bit `color` that logic returns. It drives the DAC/connector signals (sync, blank, pixel clock, RGB) with sync and blank delayed so they line up with the colour-logic latency. It sits between the game's colour logic and the board's VGA DAC, on the system clock.

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, pixels.
- `H_SYNC`, 96: hsync width, pixels.
- `H_BP`, 48: horizontal back porch, pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, lines.
- `V_SYNC`, 2: vsync width, lines.
- `V_BP`, 33: vertical back porch, lines.
- `CLK_DIV`, 2: clk cycles per pixel. Even, ≥2.
- `PIX_LAT`, 2: clk cycles from `x`/`y` change to valid `color`. Range 0..7.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `color` in 24: {R,G,B} for the coordinate issued `PIX_LAT` cycles earlier.
- `x` out 10: current horizontal count, 0..H_TOTAL-1.
- `y` out 10: current vertical count, 0..V_TOTAL-1.
- `frame_start` out 1: one-clk pulse on entry to pixel (0,0).
- `vga_clk` out 1: pixel clock to the DAC.
- `vga_hs` out 1: hsync, active-low.
- `vga_vs` out 1: vsync, active-low.
- `vga_blank_n` out 1: high while the displayed pixel is visible.
- `vga_sync_n` out 1: tied 0.
- `vga_r`, `vga_g`, `vga_b` out 8 each: pixel colour.

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - Both must be ≤1024; violating this is an elaboration error.
- Divider `div` counts 0..CLK_DIV-1 and wraps. The pixel tick `ce` = (`div`==CLK_DIV-1).
- `vga_clk` = 1 when `div` ≥ CLK_DIV/2, else 0. Rising edge at mid-pixel.
- On `ce`:
  - `x` increments. At H_TOTAL-1, `x` goes to 0 and `y` increments.
  - At `y`==V_TOTAL-1 together with `x` wrap, `y` goes to 0.
  - `x`/`y` are the counter registers themselves, with no extra delay.
- `frame_start` = 1 for exactly the clk in which `x`,`y` become 0,0.
- Raw timing signals, combinational from `x`,`y`:
  - `act` = (`x`<H_ACTIVE)&&(`y`<V_ACTIVE).
  - `hs_raw` = !(`x` ≥ H_ACTIVE+H_FP && `x` < H_ACTIVE+H_FP+H_SYNC).
  - `vs_raw` = !(`y` ≥ V_ACTIVE+V_FP && `y` < V_ACTIVE+V_FP+V_SYNC).
- `act`, `hs_raw`, `vs_raw` pass through a PIX_LAT-stage clk shift register. Each output of that shifter is then registered once more.
- `vga_r/g/b` are registered from `color` when the delayed `act` is 1, else 0.
- Net effect: all DAC outputs describe the same pixel, PIX_LAT+1 clk after its coordinate appeared.
- Colour logic that updates once per pixel must settle within CLK_DIV clk. The core does not check this.

## Timing
- Reset, asynchronous, all at once:
  - `div`=0, `x`=0, `y`=0.
  - `frame_start`=0, `vga_clk`=0.
  - `vga_hs`=1, `vga_vs`=1, `vga_blank_n`=0.
  - RGB=0, shift registers cleared to inactive.
- After release:
  - First `ce` occurs CLK_DIV clk later.
  - `frame_start` pulses first after one full frame: H_TOTAL·V_TOTAL·CLK_DIV clk = 840000.
- Frame 0 after reset starts at (0,0) with no `frame_start` pulse.
- Reset mid-frame returns everything to the reset values within the same clk. No partial-line recovery.
- Line period: H_TOTAL·CLK_DIV = 1600 clk.
- hsync low: H_SYNC·CLK_DIV = 192 clk per line.
- vsync low: V_SYNC·H_TOTAL·CLK_DIV = 3200 clk per frame.
- Output latency: `vga_hs` goes low exactly PIX_LAT+1 clk after `x` becomes H_ACTIVE+H_FP (656). `vga_vs` and `vga_blank_n` follow the same rule.
- PIX_LAT=0: the shifter is absent, leaving a single output register.

## Test plan
- Reset mid-frame at `x`=300, `y`=200 → next clk: `x`=`y`=0, `vga_hs`=`vga_vs`=1, `vga_blank_n`=0, RGB=0, `frame_start`=0.
- Free-run from reset:
  - `x` steps every 2 clk and wraps 799→0.
  - `y` increments on each wrap and wraps 524→0.
  - `frame_start` period is 840000 clk, width 1 clk.
- Sync check:
  - `vga_hs` low for 192 clk, falling 3 clk after `x` becomes 656.
  - `vga_vs` low for 3200 clk, falling 3 clk after `y` becomes 490 with `x`=0.
- Alignment, with a bench model returning `color`={x[7:0], y[7:0], 8'hA5} delayed 2 clk:
  - At every clk with `vga_blank_n`=1, `vga_r`/`vga_g` equal the x/y captured 3 clk earlier, and `vga_b`=A5.
  - RGB=0 whenever `vga_blank_n`=0.
- Porch blanking: `color`=FFFFFF constant → RGB=0 throughout `x` 640..799 and `y` 480..524 (after the 3-clk shift), `vga_blank_n`=0 there.
- `vga_clk`: 25 MHz, 50% duty, rising on `div`=1. `vga_sync_n` stays 0.
